// File: rtl/csa_resolver.sv
// Final carry-propagate stage for a carry-save pair: resolves sum + carry
// CHUNK bits per cycle, LSB chunk first, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// ADD   | resolving one chunk per cycle, chunk carry held in c_q
// DONE  | result presented with out_valid, held until out_ready
module csa_resolver #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             busy
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             cout_q;
    logic [IDX_W-1:0] base;
    logic [CHUNK:0]   chunk_add;
    logic             last_step;

    // Bit offset of the chunk being resolved this cycle.
    assign base      = IDX_W'(cnt_q) * IDX_W'(CHUNK);
    assign chunk_add = {1'b0, sum_q[base +: CHUNK]} + {1'b0, carry_q[base +: CHUNK]}
                     + (CHUNK+1)'(c_q);
    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = ADD;
            ADD:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                sum_q   <= in_sum;
                carry_q <= in_carry;
                cnt_q   <= '0;
                c_q     <= 1'b0;
            end else if (state == ADD) begin
                result_q[base +: CHUNK] <= chunk_add[CHUNK-1:0];
                c_q                     <= chunk_add[CHUNK];
                cnt_q                   <= cnt_q + CNT_W'(1);
                if (last_step) cout_q <= chunk_add[CHUNK];
            end
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_result = result_q;
    assign out_cout   = cout_q;
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver that turns a redundant carry-save pair (sum vector, carry vector) into a single two's-complement binary word. It sits after the carry-save compressor tree of the signed Booth/Wallace multiplier and performs the final addition CHUNK bits per cycle, keeping the long carry chain out of the critical path. It has valid/ready handshakes on both sides and handles one operation at a time.

## Interface

- WIDTH, 64, operand and result width in bits.
- CHUNK, 16, bits resolved per cycle; WIDTH must be an integer multiple of CHUNK; STEPS = WIDTH/CHUNK.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  carry-save sum vector.
- in_carry  input  WIDTH  carry-save carry vector, already weight-aligned (pre-shifted).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in ADD or DONE.

## Operation

- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register in_sum and in_carry, clear the step counter and the chunk carry, then go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, chunk k = counter, covering bits [k*CHUNK +: CHUNK]: {c, r} = sum_k + carry_k + c. Write r into result chunk k, update c, increment the counter.
  - After the step with counter = STEPS-1: out_cout takes the final c, and the state goes to DONE.
  - Chunks are resolved LSB first.
- DONE:
  - out_valid=1, in_ready=0.
  - out_result and out_cout are held stable.
  - On out_ready: go to IDLE.
- Arithmetic:
  - Plain unsigned modular addition. Signedness is implicit in two's complement.
  - out_cout is informational and is not an overflow flag.
  - Intermediate result chunks may change during ADD. They are only meaningful when out_valid=1.
- Inputs are sampled only at the accepting edge. in_sum and in_carry may change freely afterwards.
- in_valid while in ADD or DONE is ignored and is not queued. The upstream must hold in_valid until in_ready.
- out_ready while out_valid=0 has no effect.
- Reset (asserted at any time, including mid-ADD or in DONE):
  - The operation is aborted immediately.
  - state=IDLE, out_valid=0, out_result=0, out_cout=0, busy=0, counter=0, chunk carry=0.
  - in_ready=1 as soon as rst_n is low.

## Timing

- in_ready, out_valid and busy are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- Accept at edge E0. The state is ADD for edges E0+1 … E0+STEPS. out_valid rises after edge E0+STEPS.
- Latency from accept to out_valid is STEPS cycles: 4 at default parameters, 1 with CHUNK=WIDTH.
- With out_ready held high, the result transfers at edge E0+STEPS+1 and the state returns to IDLE. The next accept is possible at edge E0+STEPS+2.
- Peak throughput is one operation per STEPS+2 cycles.
- Backpressure: DONE persists indefinitely with the outputs constant until out_ready=1.

## Test plan

- Simple add: in_sum=0x5, in_carry=0x3 -> out_result=0x0000_0000_0000_0008, out_cout=0. out_valid is asserted exactly 4 cycles after the accept edge and in_ready is 0 throughout.
- Full carry ripple: in_sum=0xFFFF_FFFF_FFFF_FFFF, in_carry=0x1 -> out_result=0, out_cout=1. This checks carry transfer across all three chunk boundaries.
- Signed pair: in_sum=0xFFFF_FFFF_FFFF_FFFE (−2), in_carry=0x5 -> out_result=0x3, out_cout=1. Also in_sum=0x8000_0000_0000_0000 with in_carry=0x8000_0000_0000_0000 -> out_result=0, out_cout=1.
- Backpressure and ignored input: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands. Required: out_valid=1, out_result stable, in_ready=0, and the new operands are not accepted. Release out_ready -> one transfer, then IDLE.
- Reset mid-operation: deassert rst_n two cycles into ADD. Required: out_valid=0, out_result=0, in_ready=1 immediately. After release, a new operation 0x1234+0x1 returns 0x1235 with the normal 4-cycle latency.
- Random regression: run 10k back-to-back random pairs with random out_ready stalls against a (a+b) mod 2^64 model. Repeat with CHUNK=8 (8-cycle latency) and CHUNK=64 (1-cycle latency).
